// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states, reset PC and the
// prefetch-buffer entry layout.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/adder32.sv
// Shared 32-bit adder; the sum wraps modulo 2^32.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_buf.sv
// Two-entry {pc, instr} prefetch FIFO with flush, occupancy count and
// full/empty flags. Flush wins over push and pop.
module fetch_buf
  import cpu_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      // NOTE: the two entries are plain flops, so they are reset to give a zero head out of reset.
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // On a full buffer a push lands in the slot being popped this cycle.
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one memory read at a time into a
// 2-entry prefetch buffer and handles redirects without aborting requests.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        INSTR_VALID,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] INSTR_PC,
  input  logic        INSTR_READY,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] PC
);

  localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

  fetch_state_t state;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic [1:0]   buf_count;
  logic [1:0]   next_count;
  logic         buf_full;
  logic         buf_empty;
  logic         push;
  logic         pop;
  logic         room;
  logic [31:0]  redirect_al;
  logic [31:0]  pc_plus4;

  assign redirect_al = REDIRECT_PC & 32'hFFFF_FFFC;

  // A redirect flushes the buffer, drops any returning data and masks INSTR_READY.
  assign push       = (state == FETCH) && MEM_ACK && !REDIRECT;
  assign pop        = !buf_empty && INSTR_READY && !REDIRECT;
  assign push_entry = '{pc: MEM_ADDR, instr: MEM_RDATA};

  // NOTE: next_count is assigned a default first, so no latch is inferred.
  always_comb begin
    next_count = buf_count;
    if (push) next_count = next_count + 2'd1;
    if (pop)  next_count = next_count - 2'd1;
  end

  // A new request is only issued when its data is guaranteed a free slot.
  assign room = (next_count < DEPTH_CNT);

  adder32 u_pc_inc (
    .a   (PC),
    .b   (PC_INCR),
    .sum (pc_plus4)
  );

  fetch_buf u_buf (
    .CLK        (CLK),
    .RESET      (RESET),
    .flush      (REDIRECT),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (buf_count),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      PC       <= RESET_PC;
      MEM_REQ  <= 1'b0;
      MEM_ADDR <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (REDIRECT) begin
            PC       <= redirect_al;
            MEM_ADDR <= redirect_al;
            MEM_REQ  <= 1'b1;
            state    <= FETCH;
          end else if (room) begin
            MEM_ADDR <= PC;
            MEM_REQ  <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (REDIRECT) begin
            PC <= redirect_al;
            if (MEM_ACK) MEM_ADDR <= redirect_al;
            else         state    <= DISCARD;
          end else if (MEM_ACK) begin
            PC <= pc_plus4;
            if (room) begin
              MEM_ADDR <= pc_plus4;
            end else begin
              MEM_REQ <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        DISCARD: begin
          // The stale request stays on the bus until acked; its data is dropped.
          if (REDIRECT) PC <= redirect_al;
          if (MEM_ACK) begin
            MEM_ADDR <= REDIRECT ? redirect_al : PC;
            state    <= FETCH;
          end
        end
        default: begin
          MEM_REQ <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign INSTR_VALID = !buf_empty;
  assign INSTRUCTION = head.instr;
  assign INSTR_PC    = head.pc;

  assert property (@(posedge CLK) disable iff (RESET)
                   !(push && buf_full && !pop) && !(pop && buf_empty));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// traffic compared against a transaction-level queue model.
module tb_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        rand_mode;
  logic [31:0] rand_rdata;

  // Second instance starting near the top of the address space.
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack   = 1'b1;
  logic [31:0] w_rdata = 32'h1234_5678;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;
  logic        w_ready = 1'b1;
  logic        w_redir = 1'b0;
  logic [31:0] w_rpc   = 32'h0;
  logic [31:0] w_pc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5EED_0001;
  endfunction

  assign mem_rdata = rand_mode ? rand_rdata : data_of(mem_addr);

  fetch_ctrl dut (
    .CLK(CLK), .RESET(RESET), .MEM_REQ(mem_req), .MEM_ADDR(mem_addr), .MEM_ACK(mem_ack),
    .MEM_RDATA(mem_rdata), .INSTR_VALID(instr_valid), .INSTRUCTION(instruction),
    .INSTR_PC(instr_pc), .INSTR_READY(instr_ready), .REDIRECT(redirect),
    .REDIRECT_PC(redirect_pc), .PC(pc)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .CLK(CLK), .RESET(RESET), .MEM_REQ(w_req), .MEM_ADDR(w_addr), .MEM_ACK(w_ack),
    .MEM_RDATA(w_rdata), .INSTR_VALID(w_valid), .INSTRUCTION(w_instr),
    .INSTR_PC(w_instr_pc), .INSTR_READY(w_ready), .REDIRECT(w_redir),
    .REDIRECT_PC(w_rpc), .PC(w_pc)
  );

  // Reference model: prefetch queue, one pending read, and the next fetch address.
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        q[$];
  bit          m_pend;
  bit          m_drop;
  logic [31:0] m_addr;
  logic [31:0] m_npc;
  logic        s_reset, s_ack, s_ready, s_redir;
  logic [31:0] s_rdata, s_rpc;

  task automatic model_edge();
    bit hit;
    if (s_reset) begin
      q.delete();
      m_pend = 0;
      m_drop = 0;
      m_npc  = 32'h0;
      return;
    end
    hit = m_pend && s_ack;
    if (s_redir) begin
      q.delete();
      m_npc = {s_rpc[31:2], 2'b00};
      if (hit) m_pend = 0;
      else if (m_pend) m_drop = 1;
    end else begin
      if (q.size() > 0 && s_ready) void'(q.pop_front());
      if (hit) begin
        if (!m_drop) begin
          q.push_back(ent_t'{pc: m_addr, instr: s_rdata});
          m_npc = m_npc + 32'd4;
        end
        m_pend = 0;
      end
    end
    if (!m_pend && q.size() < 2) begin
      m_pend = 1;
      m_drop = 0;
      m_addr = m_npc;
    end
  endtask

  // Inputs are sampled on the falling edge; outputs are observed 1 after the rising edge.
  task automatic tick();
    @(negedge CLK);
    s_reset = RESET;  s_ack = mem_ack;     s_ready = instr_ready;
    s_redir = redirect; s_rdata = mem_rdata; s_rpc = redirect_pc;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; rand_mode = 1'b0; rand_rdata = 32'h0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if ({mem_req, instr_valid} !== 2'b00) $display("FAIL reset_req_valid: got %b expected 00", {mem_req, instr_valid}); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); else n_pass++;
    n_checks++; if ({instruction, instr_pc} !== 64'h0) $display("FAIL reset_head: got %h/%h expected 0/0", instruction, instr_pc); else n_pass++;
    n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h expected 0", pc); else n_pass++;
    n_checks++; if (w_pc !== 32'hFFFF_FFF8) $display("FAIL reset_pc_param: got %h expected fffffff8", w_pc); else n_pass++;
    mem_ack = 1'b1;  // ack while no request is active must be ignored
    tick();
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) $display("FAIL first_req: got %b/%h expected 1/0", mem_req, mem_addr); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL stray_ack: valid=%b expected 0", instr_valid); else n_pass++;
  endtask

  task automatic test_stream();
    apply_reset();
    mem_ack = 1'b1; instr_ready = 1'b1;
    tick();
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'(4 * i)}) $display("FAIL stream_addr %0d: got %b/%h expected 1/%h", i, mem_req, mem_addr, 4 * i); else n_pass++;
      n_checks++; if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'(4 * (i - 1)), data_of(32'(4 * (i - 1)))})
        $display("FAIL stream_head %0d: got %b/%h/%h expected pc %h", i, instr_valid, instr_pc, instruction, 4 * (i - 1)); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    mem_ack = 1'b1; instr_ready = 1'b0;
    tick(); tick(); tick();
    n_checks++; if ({mem_req, pc} !== {1'b0, 32'h8}) $display("FAIL bp_full: got req %b pc %h expected 0/8", mem_req, pc); else n_pass++;
    n_checks++; if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) $display("FAIL bp_head: got %b/%h expected 1/0", instr_valid, instr_pc); else n_pass++;
    tick(); tick();
    n_checks++; if (mem_req !== 1'b0) $display("FAIL bp_hold: req=%b expected 0", mem_req); else n_pass++;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    n_checks++; if ({mem_req, mem_addr, instr_pc} !== {1'b1, 32'h8, 32'h4}) $display("FAIL bp_refill: got %b/%h head %h expected 1/8 head 4", mem_req, mem_addr, instr_pc); else n_pass++;
    tick();
    n_checks++; if ({mem_req, pc, instr_pc} !== {1'b0, 32'hC, 32'h4}) $display("FAIL bp_single: got req %b pc %h head %h expected 0/c/4", mem_req, pc, instr_pc); else n_pass++;
  endtask

  task automatic test_redirect_pending();
    apply_reset();
    instr_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    n_checks++; if ({mem_req, mem_addr, pc} !== {1'b1, 32'h0, 32'h100}) $display("FAIL rp_discard: got %b/%h pc %h expected 1/0 pc 100", mem_req, mem_addr, pc); else n_pass++;
    tick();
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) $display("FAIL rp_stable: got %b/%h expected 1/0", mem_req, mem_addr); else n_pass++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    n_checks++; if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) $display("FAIL rp_refetch: got %b/%h valid %b expected 1/100 valid 0", mem_req, mem_addr, instr_valid); else n_pass++;
    tick();
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL rp_dropped: valid=%b expected 0", instr_valid); else n_pass++;
    mem_ack = 1'b1;
    tick();
    n_checks++; if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'h100, data_of(32'h100)}) $display("FAIL rp_new_head: got %b/%h/%h expected pc 100", instr_valid, instr_pc, instruction); else n_pass++;
  endtask

  task automatic test_redirect_with_ack();
    apply_reset();
    mem_ack = 1'b1; instr_ready = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (mem_addr !== 32'h8) $display("FAIL ra_setup: addr %h expected 8", mem_addr); else n_pass++;
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    n_checks++; if ({mem_req, mem_addr, pc, instr_valid} !== {1'b1, 32'h40, 32'h40, 1'b0}) $display("FAIL ra_flush: got %b/%h pc %h valid %b expected 1/40 pc 40 valid 0", mem_req, mem_addr, pc, instr_valid); else n_pass++;
    tick();
    n_checks++; if ({instr_valid, instr_pc, mem_addr} !== {1'b1, 32'h40, 32'h44}) $display("FAIL ra_resume: got %b/%h addr %h expected 1/40 addr 44", instr_valid, instr_pc, mem_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC; exp_addr[2] = 32'h0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({w_req, w_addr} !== {1'b1, exp_addr[i]}) $display("FAIL wrap_addr %0d: got %b/%h expected 1/%h", i, w_req, w_addr, exp_addr[i]); else n_pass++;
    end
    n_checks++; if ({w_valid, w_instr_pc} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_head: got %b/%h expected 1/fffffffc", w_valid, w_instr_pc); else n_pass++;
  endtask

  task automatic test_reset_midrequest();
    apply_reset();
    mem_ack = 1'b1;
    tick(); tick();
    mem_ack = 1'b0;
    tick();
    n_checks++; if ({mem_req, instr_valid} !== 2'b11) $display("FAIL mr_setup: got %b expected 11", {mem_req, instr_valid}); else n_pass++;
    RESET = 1'b1; mem_ack = 1'b1;
    tick();
    RESET = 1'b0; mem_ack = 1'b0;
    n_checks++; if ({mem_req, mem_addr, instr_valid, instruction, instr_pc, pc} !== 130'h0)
      $display("FAIL mr_reset: req %b addr %h valid %b instr %h ipc %h pc %h expected all 0", mem_req, mem_addr, instr_valid, instruction, instr_pc, pc); else n_pass++;
    tick();
    n_checks++; if ({mem_req, mem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) $display("FAIL mr_restart: got %b/%h valid %b expected 1/0 valid 0", mem_req, mem_addr, instr_valid); else n_pass++;
    mem_ack = 1'b1;
    tick();
    n_checks++; if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'h0, data_of(32'h0)}) $display("FAIL mr_first_data: got %b/%h/%h expected pc 0", instr_valid, instr_pc, instruction); else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    rand_mode = 1'b1;
    for (int c = 0; c < 600; c++) begin
      mem_ack     = ($urandom_range(0, 99) < 55);
      instr_ready = ($urandom_range(0, 99) < 60);
      redirect    = ($urandom_range(0, 99) < 8);
      redirect_pc = $urandom;
      rand_rdata  = $urandom;
      tick();
      n_checks++; if (mem_req !== m_pend || pc !== m_npc) $display("FAIL rand_ctrl cycle %0d: req %b pc %h expected req %b pc %h", c, mem_req, pc, m_pend, m_npc); else n_pass++;
      if (m_pend) begin
        n_checks++; if (mem_addr !== m_addr) $display("FAIL rand_addr cycle %0d: got %h expected %h", c, mem_addr, m_addr); else n_pass++;
      end
      n_checks++; if (instr_valid !== (q.size() > 0)) $display("FAIL rand_valid cycle %0d: got %b expected %b", c, instr_valid, q.size() > 0); else n_pass++;
      if (q.size() > 0) begin
        n_checks++; if ({instr_pc, instruction} !== {q[0].pc, q[0].instr}) $display("FAIL rand_head cycle %0d: got %h/%h expected %h/%h", c, instr_pc, instruction, q[0].pc, q[0].instr); else n_pass++;
      end
    end
    rand_mode = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_pending();
    test_redirect_with_ack();
    test_wrap();
    test_reset_midrequest();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, prefetch buffer entries; only 2 is supported.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 MEM_REQ  output  1  instruction memory read request.
REQ-006 MEM_ADDR  output  32  word-aligned read address, valid while MEM_REQ=1.
REQ-007 MEM_ACK  input  1  memory accepts the request and returns data this cycle.
REQ-008 MEM_RDATA  input  32  instruction word, valid when MEM_ACK=1.
REQ-009 INSTR_VALID  output  1  buffer head holds an instruction.
REQ-010 INSTRUCTION  output  32  buffer head instruction word.
REQ-011 INSTR_PC  output  32  address of the buffer head instruction.
REQ-012 INSTR_READY  input  1  CPU consumes the head when INSTR_VALID=1.
REQ-013 REDIRECT  input  1  branch/jump taken; flush and refetch.
REQ-014 REDIRECT_PC  input  32  new fetch address; bits [1:0] are ignored and forced to 0.
REQ-015 PC  output  32  next address to be requested.

Function
REQ-016 FSM states SHALL be IDLE, FETCH and DISCARD.
REQ-017 IDLE->FETCH when free entries minus outstanding requests > 0; MEM_REQ=1 and MEM_ADDR=PC are registered outputs in FETCH.
REQ-018 In FETCH, MEM_REQ and MEM_ADDR SHALL hold stable until MEM_ACK=1; requests are never aborted; at most one is outstanding.
REQ-019 On MEM_ACK in FETCH: push {PC, MEM_RDATA}; PC <= PC+4 (32-bit wrap, 32'hFFFF_FFFC -> 0); stay in FETCH if a second free entry exists, else go to IDLE.
REQ-020 MEM_ACK while MEM_REQ=0 SHALL be ignored.
REQ-021 Ack-to-INSTR_VALID latency is 1 cycle when the buffer was empty.
REQ-022 Pop occurs when INSTR_VALID & INSTR_READY; a simultaneous push and pop on a full buffer is legal and leaves it full.
REQ-023 On REDIRECT: flush the buffer (INSTR_VALID=0 next cycle) and set PC <= {REDIRECT_PC[31:2],2'b00}.
REQ-024 REDIRECT in FETCH without MEM_ACK -> DISCARD: keep the request stable; its ack data is dropped; then go to FETCH at the new PC.
REQ-025 REDIRECT in the same cycle as MEM_ACK: drop the ack data, do not increment PC, next state FETCH at the new PC.
REQ-026 REDIRECT in DISCARD: update PC again; remain in DISCARD.
REQ-027 REDIRECT has priority over push and pop in the same cycle; INSTR_READY is ignored that cycle.
REQ-028 Buffer overflow and underflow SHALL be impossible by construction; an assertion checks both.

Reset
REQ-029 RESET=1 at a clock edge: state=IDLE, PC=RESET_PC, MEM_REQ=0, MEM_ADDR=0, buffer empty, INSTR_VALID=0, INSTRUCTION=0, INSTR_PC=0.
REQ-030 Reset mid-request abandons the request without waiting for MEM_ACK; an ack in the reset cycle is ignored.
REQ-031 On the first edge after RESET falls: MEM_REQ=1, MEM_ADDR=RESET_PC.

Structure
REQ-032 Shared package cpu_pkg SHALL hold the fetch_state_t enum (IDLE/FETCH/DISCARD), RESET_PC_DEFAULT and the 32'd4 PC increment constant.
REQ-033 The PC increment SHALL reuse the team's existing 32-bit adder module.
REQ-034 One sub-module, fetch_buf (2-entry {pc,instr} FIFO with flush, count, full/empty), SHALL hold the buffer.

Verification
REQ-035 Reset, MEM_ACK always 1, INSTR_READY always 1 -> addresses 0,4,8,… issued back-to-back; INSTR_PC follows one cycle behind.
REQ-036 INSTR_READY=0, MEM_ACK=1 -> exactly 2 acks accepted (addresses 0 and 4), then MEM_REQ=0; INSTR_READY=1 for one cycle -> single request at address 8.
REQ-037 MEM_ACK delayed 3 cycles, REDIRECT to 32'h0000_0103 in cycle 1 -> MEM_ADDR held at 0 until ack, data dropped, next MEM_ADDR=32'h0000_0100, no INSTR_VALID for address 0.
REQ-038 REDIRECT to 32'h40 coincident with MEM_ACK at address 8 -> ack dropped, buffer flushed, next MEM_ADDR=32'h40.
REQ-039 RESET_PC=32'hFFFF_FFF8, acks always 1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 RESET asserted during an outstanding request with a late ack -> all outputs at reset values, and the first request after release is at RESET_PC.
